// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, FSM state type and helpers
// for the interrupt pending/presentation controller.
package irq_pending_ctrl_pkg;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Decode a source index into its one-hot bit.
   function automatic logic [NUM_SRC-1:0] id_onehot(
      input logic [ID_W-1:0] id
   );
      id_onehot     = '0;
      id_onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// 8-input priority encoder, bit 7 highest.
// Purely combinational; any=0 means idx is don't-care (0).
module prio_enc8
   import irq_pending_ctrl_pkg::*;
(
   input  logic [7:0]      in_vec,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (in_vec[i]) begin
            idx = ID_W'(i);
         end
      end
      any = |in_vec;
   end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-detecting interrupt pending register with a
// single-grant valid/ready presentation FSM.
module irq_pending_ctrl #(
   parameter int NUM_SRC = irq_pending_ctrl_pkg::NUM_SRC
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SRC-1:0]               req,
   input  logic [NUM_SRC-1:0]               mask,
   input  logic                             en,
   input  logic                             ovf_clr,
   input  logic                             irq_ready,
   output logic                             irq_valid,
   output logic [irq_pending_ctrl_pkg::ID_W-1:0] irq_id,
   output logic [NUM_SRC-1:0]               pending,
   output logic                             overflow
);

   import irq_pending_ctrl_pkg::*;

   logic [NUM_SRC-1:0] req_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] pending_nx;
   logic               ovf_set;
   logic               ovf_nx;
   logic               sel_any;
   logic [ID_W-1:0]    sel_id;
   logic [ID_W-1:0]    id_nx;
   state_t             state;
   state_t             state_nx;

   assign irq_valid = (state == PRESENT);
   assign rise      = req & ~req_d;
   assign clr       = (irq_valid && irq_ready) ? id_onehot(irq_id) : '0;
   assign eligible  = pending & ~mask;

   prio_enc8 u_prio (
      .in_vec (eligible),
      .idx    (sel_id),
      .any    (sel_any)
   );

   // Pending and overflow update: a rise always wins over a clear,
   // and only a rise onto a still-pending bit counts as overflow.
   always_comb begin
      pending_nx = (pending & ~clr) | rise;
      ovf_set    = |(rise & pending & ~clr);
      ovf_nx     = ovf_set | (overflow & ~ovf_clr);
   end

   // Grant FSM: latch the winner once, hold it until accepted.
   always_comb begin
      state_nx = state;
      id_nx    = irq_id;
      unique case (state)
         IDLE: begin
            if (en && sel_any) begin
               state_nx = PRESENT;
               id_nx    = sel_id;
            end
         end
         PRESENT: begin
            if (irq_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // All controller state in one register process.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_d    <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         irq_id   <= '0;
         state    <= IDLE;
      end else begin
         req_d    <= req;
         pending  <= pending_nx;
         overflow <= ovf_nx;
         irq_id   <= id_nx;
         state    <= state_nx;
      end
   end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req  input  8  level request lines; bit 7 is the highest priority.
REQ-004 SHALL have port mask  input  8  per-source mask; 1 = source not eligible for service.
REQ-005 SHALL have port en  input  1  global service enable; 0 = no new grant is started.
REQ-006 SHALL have port ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-007 SHALL have port irq_ready  input  1  consumer accepts the presented id.
REQ-008 SHALL have port irq_valid  output  1  an id is presented.
REQ-009 SHALL have port irq_id  output  3  index of the granted source, 0..7.
REQ-010 SHALL have port pending  output  8  registered pending bits, masked and unmasked.
REQ-011 SHALL have port overflow  output  1  sticky flag: a rise arrived while the same bit was already pending.
REQ-012 SHALL have parameter NUM_SRC, default 8, giving the source count; only 8 is supported.

Function
REQ-013 SHALL register req into req_d each cycle; rise[i] = req[i] & ~req_d[i].
REQ-014 SHALL update pending each cycle as pending_next = (pending & ~clr) | rise, so a set wins over a same-cycle clear.
REQ-015 SHALL form clr as a one-hot vector at irq_id, only in a cycle where irq_valid & irq_ready is high; otherwise clr is 0.
REQ-016 SHALL form eligible = pending & ~mask and select the highest set index, with bit 7 winning.
REQ-017 SHALL implement a two-state FSM with states IDLE and PRESENT.
REQ-018 In IDLE, when en=1 and eligible!=0, the FSM SHALL register the selected index into irq_id and enter PRESENT; otherwise it stays in IDLE.
REQ-019 In PRESENT, irq_valid SHALL be 1, and irq_id SHALL hold stable until the handshake completes, even if a higher-priority rise, a mask change or en=0 occurs.
REQ-020 In PRESENT, irq_valid & irq_ready SHALL clear pending[irq_id] and return the FSM to IDLE, leaving a minimum one-cycle gap between grants.
REQ-021 irq_valid SHALL be 0 in IDLE.
REQ-022 Latency SHALL be as follows: a rise sampled at edge k sets pending after edge k; irq_valid is high after edge k+1 if the FSM is in IDLE and the source is eligible.
REQ-023 A rise on bit i with pending[i]=1 and no same-cycle clear of bit i SHALL set overflow; pending[i] stays 1 and the rise is not counted twice.
REQ-024 A rise on bit i in the same cycle as the clear of bit i SHALL leave pending[i]=1 and SHALL NOT set overflow.
REQ-025 ovf_clr=1 SHALL clear overflow on the next edge; a same-cycle overflow set takes priority over the clear.
REQ-026 Masked pending bits SHALL be retained and SHALL become eligible in the cycle after the mask is removed.

Reset
REQ-027 rst=1 SHALL asynchronously force req_d=0, pending=0, overflow=0, irq_id=0, FSM=IDLE, and irq_valid=0.
REQ-028 A req held high through reset SHALL be treated as a rise at the first edge after rst deasserts.
REQ-029 Reset asserted while in PRESENT SHALL drop irq_valid immediately and discard the outstanding grant.

Structure
REQ-030 A shared package SHALL hold NUM_SRC=8, ID_W=3, and the FSM state enum (IDLE, PRESENT).
REQ-031 Selection SHALL be a combinational sub-module prio_enc8 (8-bit in, 3-bit index plus any-valid out, bit 7 highest).
REQ-032 All state SHALL live in a single clocked process in irq_pending_ctrl.

Verification
REQ-033 Single source: req=0x01 from cycle 2 with ready=1 -> irq_valid high at cycle 4 with irq_id=0; pending returns to 0x00 after the handshake.
REQ-034 Priority: rises on 0x81 in the same cycle -> id 7 is granted first, then id 0 after a one-cycle gap.
REQ-035 Hold: ready=0 while id=2 is presented, then a rise on bit 6 -> irq_id stays 2 until ready; id 6 is granted next.
REQ-036 Masking: mask=0x08 with a rise on bit 3 -> no irq_valid and pending=0x08; mask cleared -> id 3 is granted two cycles later.
REQ-037 Overflow and simultaneity: a second rise on pending bit 4 sets overflow; a rise coinciding with its own clear leaves pending[4]=1 and overflow unchanged; ovf_clr clears the flag.
REQ-038 Reset mid-grant: rst pulsed while in PRESENT -> irq_valid drops asynchronously and all outputs read 0.
